// File: rtl/traffic_intersection.sv
// rtl/traffic_intersection.sv - two-road intersection controller with all-red clearance, walk phase and night flash
module traffic_intersection #(
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int WALK_CYCLES   = 8,
  parameter int FLASH_HALF    = 5,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    ARB, NS_G, NS_Y, ARA, EW_G, EW_Y, WALK, FLASH
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] A_LD = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_LD = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] F_LD = CNT_W'(FLASH_HALF - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             blink, blink_n;
  logic             from_ara, from_ara_n;
  logic             pend, pend_n;

  function automatic logic [CNT_W-1:0] load_of(state_t st);
    case (st)
      NS_G, EW_G: load_of = G_LD;
      NS_Y, EW_Y: load_of = Y_LD;
      WALK:       load_of = W_LD;
      FLASH:      load_of = F_LD;
      default:    load_of = A_LD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      cnt      <= A_LD;
      blink    <= 1'b1;
      from_ara <= 1'b0;
      pend     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      blink    <= blink_n;
      from_ara <= from_ara_n;
      pend     <= pend_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt - CNT_W'(1);
    blink_n    = blink;
    from_ara_n = from_ara;
    // Requests arriving while the walk is being served are dropped.
    pend_n     = (state == WALK) ? pend : (pend | ped_req);

    if (cnt == '0) begin
      case (state)
        ARB, ARA: begin
          if (flash_mode) begin
            state_n = FLASH;
            blink_n = 1'b1;
          end else if (pend) begin
            state_n    = WALK;
            from_ara_n = (state == ARA);
            pend_n     = 1'b0;
          end else begin
            state_n = (state == ARB) ? NS_G : EW_G;
          end
        end
        NS_G:    state_n = NS_Y;
        NS_Y:    state_n = ARA;
        EW_G:    state_n = EW_Y;
        EW_Y:    state_n = ARB;
        WALK:    state_n = from_ara ? EW_G : NS_G;
        default: begin
          if (flash_mode) begin
            blink_n = ~blink;
          end else begin
            state_n = ARB;
          end
        end
      endcase
      cnt_n = load_of(state_n);
    end
  end

  always_comb begin
    ns_light    = RED;
    ew_light    = RED;
    ped_walk    = 1'b0;
    ped_pending = pend;
    case (state)
      NS_G:  ns_light = GREEN;
      NS_Y:  ns_light = YELLOW;
      EW_G:  ew_light = GREEN;
      EW_Y:  ew_light = YELLOW;
      WALK:  ped_walk = 1'b1;
      FLASH: begin
        ns_light = {1'b0, blink, 1'b0};
        ew_light = {1'b0, blink, 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_intersection.sv
// tb/tb_traffic_intersection.sv - directed vector bench for traffic_intersection
module tb_traffic_intersection;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ped_req = 1'b0;
  logic       flash_mode = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic       ped_walk, ped_pending;

  traffic_intersection #(
    .GREEN_CYCLES(4), .YELLOW_CYCLES(2), .ALLRED_CYCLES(1),
    .WALK_CYCLES(3), .FLASH_HALF(2), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .flash_mode(flash_mode),
    .ns_light(ns_light), .ew_light(ew_light),
    .ped_walk(ped_walk), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, D = 3'b000;

  typedef struct {
    logic       req;
    logic       fm;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic       pend;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic push(input int n, input logic req, input logic fm, input logic [2:0] ns,
                      input logic [2:0] ew, input logic walk, input logic pend);
    vec_t v;
    v.req = req; v.fm = fm; v.ns = ns; v.ew = ew; v.walk = walk; v.pend = pend;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [2:0] ns, input logic [2:0] ew,
                       input logic walk, input logic pend);
    logic safe;
    applied++;
    safe = (ns_light == R) || (ew_light == R) ||
           ((ns_light == ew_light) && (ns_light == Y || ns_light == D));
    if ({ns_light, ew_light, ped_walk, ped_pending} !== {ns, ew, walk, pend} || !safe) begin
      miscompares++;
      $display("FAIL %s #%0d: got ns=%b ew=%b walk=%b pend=%b, want ns=%b ew=%b walk=%b pend=%b (safe=%b)",
               name, idx, ns_light, ew_light, ped_walk, ped_pending, ns, ew, walk, pend, safe);
    end
  endtask

  // Each iteration starts on a falling edge: drive inputs, check the Moore outputs, move on.
  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      ped_req    = vecs[i].req;
      flash_mode = vecs[i].fm;
      #1;
      check("vec", i, vecs[i].ns, vecs[i].ew, vecs[i].walk, vecs[i].pend);
      @(negedge clk);
    end
  endtask

  task automatic push_cycle();
    push(1, 0, 0, R, R, 0, 0);
    push(4, 0, 0, G, R, 0, 0);
    push(2, 0, 0, Y, R, 0, 0);
    push(1, 0, 0, R, R, 0, 0);
    push(4, 0, 0, R, G, 0, 0);
    push(2, 0, 0, R, Y, 0, 0);
    push(1, 0, 0, R, R, 0, 0);
  endtask

  int mark;

  initial begin
    // Reset and plain cycling
    push_cycle();
    // Request pulse in NS_G, served after ARA, resumes at EW_G
    push(1, 1, 0, G, R, 0, 0);
    push(3, 0, 0, G, R, 0, 1);
    push(2, 0, 0, Y, R, 0, 1);
    push(1, 0, 0, R, R, 0, 1);
    push(3, 0, 0, R, R, 1, 0);
    push(4, 0, 0, R, G, 0, 0);
    push(2, 0, 0, R, Y, 0, 0);
    push(1, 0, 0, R, R, 0, 0);
    push(4, 0, 0, G, R, 0, 0);
    push(2, 0, 0, Y, R, 0, 0);
    // Request on the last ARA clock is late; served at ARB; requests in WALK dropped
    push(1, 1, 0, R, R, 0, 0);
    push(4, 0, 0, R, G, 0, 1);
    push(2, 0, 0, R, Y, 0, 1);
    push(1, 0, 0, R, R, 0, 1);
    push(3, 1, 0, R, R, 1, 0);
    push(4, 0, 0, G, R, 0, 0);
    push(2, 0, 0, Y, R, 0, 0);
    push(1, 0, 0, R, R, 0, 0);
    // Flash raised in EW_G: greens finish, flash from ARB, exit at half boundary
    push(4, 0, 1, R, G, 0, 0);
    push(2, 0, 1, R, Y, 0, 0);
    push(1, 0, 1, R, R, 0, 0);
    push(2, 0, 1, Y, Y, 0, 0);
    push(2, 0, 1, D, D, 0, 0);
    push(2, 0, 0, Y, Y, 0, 0);
    push(1, 0, 0, R, R, 0, 0);
    push(4, 0, 0, G, R, 0, 0);
    push(2, 0, 0, Y, R, 0, 0);
    push(1, 0, 0, R, R, 0, 0);
    // Flash beats pending request; walk follows once flash ends
    push(1, 1, 1, R, G, 0, 0);
    push(3, 1, 1, R, G, 0, 1);
    push(2, 1, 1, R, Y, 0, 1);
    push(1, 1, 1, R, R, 0, 1);
    push(2, 1, 1, Y, Y, 0, 1);
    push(2, 1, 0, D, D, 0, 1);
    push(1, 1, 0, R, R, 0, 1);
    push(3, 0, 0, R, R, 1, 0);
    push(4, 0, 0, G, R, 0, 0);
    // Enter WALK again for the mid-WALK reset
    push(1, 1, 0, Y, R, 0, 0);
    push(1, 0, 0, Y, R, 0, 1);
    push(1, 0, 0, R, R, 0, 1);
    push(1, 0, 0, R, R, 1, 0);
    mark = vecs.size();
    push_cycle();
    push(4, 0, 0, G, R, 0, 0);

    // Reset held for 2 clocks with a request present
    ped_req = 1'b1;
    @(negedge clk);
    check("reset_hold", 0, R, R, 0, 0);
    @(negedge clk);
    check("reset_hold", 1, R, R, 0, 0);
    reset = 1'b0;
    run(0, mark);

    // Asynchronous reset between edges, second WALK clock
    check("walk_before_reset", 0, R, R, 1, 0);
    #2 reset = 1'b1;
    #1 check("async_reset", 0, R, R, 0, 0);
    @(negedge clk);
    check("async_reset", 1, R, R, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    run(mark, vecs.size());

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_intersection.md
# traffic_intersection

Parametrised two-road intersection controller and successor to the single-signal `traffic_light`. It sequences a north-south (NS) and an east-west (EW) signal head with programmable phase lengths and an all-red clearance interval between greens. It also serves latched pedestrian requests with a dedicated walk phase and supports a night flashing-yellow mode. It sits directly behind the lamp drivers and keeps the existing 3-bit light encoding.

## Interface
- `GREEN_CYCLES`, default 20: length of each green phase in clocks, at least 1.
- `YELLOW_CYCLES`, default 4: length of each yellow phase in clocks, at least 1.
- `ALLRED_CYCLES`, default 2: length of each all-red clearance phase in clocks, at least 1.
- `WALK_CYCLES`, default 8: length of the pedestrian walk phase in clocks, at least 1.
- `FLASH_HALF`, default 5: clocks per half-period of the flashing yellow, at least 1.
- `CNT_W`, default 8: phase counter width. It must hold the largest of the duration parameters minus 1.

Ports:
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `ped_req` input 1: pedestrian request, sampled each clock, any length.
- `flash_mode` input 1: level request for night flashing mode.
- `ns_light` output 3: NS head, {red, yellow, green}, one-hot or all-zero.
- `ew_light` output 3: EW head, same encoding as `ns_light`.
- `ped_walk` output 1: walk indication.
- `ped_pending` output 1: pedestrian request latched and not yet served.

## Operation
- Moore FSM with states ARB (all-red before NS), NS_G, NS_Y, ARA (all-red before EW), EW_G, EW_Y, WALK, FLASH. Outputs decode from the state register only.
- Light outputs by state:
  - NS_G: NS=001, EW=100.
  - NS_Y: NS=010, EW=100.
  - EW_G: NS=100, EW=001.
  - EW_Y: NS=100, EW=010.
  - ARA, ARB, WALK: both 100.
  - FLASH: both {0,blink,0}.
- `ped_walk` is 1 only in WALK.
- Phase counter: loaded with duration−1 on entry to every state and decremented each clock. The state exits on the clock where the counter is 0. Every state therefore lasts exactly its parameter in cycles.
- Normal order: ARB → NS_G → NS_Y → ARA → EW_G → EW_Y → ARB.
- Exit decision at the end of ARA or ARB, in priority order:
  1. `flash_mode`=1 → FLASH.
  2. Else `ped_pending`=1 → WALK.
  3. Else the next green.
- WALK records which all-red state it came from (one flop). It exits to NS_G if entered from ARB, or to EW_G if entered from ARA.
- `ped_pending`:
  - Set on any clock with `ped_req`=1.
  - Cleared on the clock that enters WALK. If `ped_req`=1 on that same clock, the clear wins.
  - `ped_req` during WALK is ignored.
  - The pending latch is retained through FLASH.
- FLASH:
  - `blink` starts at 1 on entry and toggles every FLASH_HALF cycles, using the phase counter reloaded each half.
  - At a half-period boundary (counter 0) with `flash_mode`=0, the FSM goes to ARB and normal operation resumes with NS first.
  - `flash_mode` outside all-red phases has no effect until the next all-red exit. A green is never cut short.
- Safety invariant: at no time are both heads non-red, except in FLASH where both are yellow or dark.

## Timing
- `reset`=1 asynchronously forces:
  - state ARB, counter ALLRED_CYCLES−1;
  - `ns_light`=`ew_light`=100;
  - `ped_walk`=0, `ped_pending`=0;
  - `blink`=1, WALK-origin flop=0.
- This holds from any state, including mid-WALK or mid-FLASH.
- After reset deasserts, ARB lasts ALLRED_CYCLES clocks, then NS_G begins.
- Normal cycle period is 2·(GREEN+YELLOW+ALLRED) clocks. A served request adds WALK_CYCLES once.
- `ped_req` affects `ped_pending` one clock after the sampling edge. A request seen at the last ARA/ARB clock is too late for that exit and is served at the next all-red.
- `flash_mode` is sampled only at all-red exits and FLASH half boundaries. There is no synchroniser inside; callers synchronise it.

## Test plan
Bench parameters: GREEN=4, YELLOW=2, ALLRED=1, WALK=3, FLASH_HALF=2.

1. **Reset and cycling.** Reset for 2 clocks, then release. Expect 1 clock of 100/100, then NS=001 for 4, NS=010 for 2, 100/100 for 1, EW=001 for 4, EW=010 for 2, 100/100 for 1. The pattern repeats every 14 clocks.
2. **Pedestrian request during NS_G.** Pulse `ped_req` for 1 clock. Expect `ped_pending`=1 the next clock. After ARA, expect WALK for 3 clocks with `ped_walk`=1 and both heads 100, then EW_G. `ped_pending` clears on WALK entry.
3. **Request on the last all-red clock, plus request inside WALK.** Expect no WALK at this exit and service at the following all-red. A `ped_req` held during WALK leaves `ped_pending`=0 after WALK.
4. **Flash mode.** Raise `flash_mode` during EW_G. Expect EW_G and EW_Y to complete, then ARB, then FLASH with both heads 010 for 2 clocks and 000 for 2 clocks, repeating. Drop `flash_mode` and expect exit at the next half boundary to ARB (1 clock), then NS_G.
5. **Flash plus pending request.** Hold `ped_req` and `flash_mode` together. Expect FLASH to take priority with `ped_pending` staying 1. After flash exits, expect WALK at the ARB exit.
6. **Asynchronous reset mid-WALK.** Assert `reset` between clock edges. Expect immediate 100/100, `ped_walk`=0, `ped_pending`=0, and a clean restart as in scenario 1. Throughout all scenarios, assert the safety invariant every cycle.
